// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state encodings,
// error codes and stream framing.
package imem_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_LEN0 = 3'd1;
    localparam state_t S_LEN1 = 3'd2;
    localparam state_t S_DATA = 3'd3;
    localparam state_t S_CHK  = 3'd4;
    localparam state_t S_FILL = 3'd5;
    localparam state_t S_DONE = 3'd6;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: bytes enter at the top and shift down,
// so the first byte of a word ends up in bits [7:0].
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic              word_last,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    logic [1:0] cnt;

    // High while the byte being accepted completes a word.
    assign word_last = byte_en && (cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= word_last;
            if (clear) begin
                cnt <= '0;
            end else if (byte_en) begin
                cnt <= cnt + 2'd1;
            end
            if (byte_en) begin
                word <= {byte_in, word[DATA_W-1:8]};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed program image into instruction RAM,
// zero-fills the remainder and holds the CPU until a load succeeds.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LAST_IDX = DEPTH - ONE;

    state_t            state;
    logic [7:0]        len_lo;
    logic [15:0]       len16;
    logic [ADDR_W:0]   n;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   idx_next;
    logic [7:0]        sum;
    logic              xfer;
    logic              idle_like;
    logic              pack_en;
    logic              pack_clear;
    logic              word_last;
    logic              word_valid;
    logic [DATA_W-1:0] word;

    assign idle_like  = (state == S_IDLE) || (state == S_DONE);
    assign in_ready   = (state == S_LEN0) || (state == S_LEN1) ||
                        (state == S_DATA) || (state == S_CHK);
    assign busy       = !idle_like;
    assign xfer       = in_valid && in_ready;
    assign pack_en    = xfer && (state == S_DATA);
    assign pack_clear = start && idle_like;
    assign len16      = {in_data, len_lo};
    assign idx_next   = word_valid ? (idx + ONE) : idx;

    // idx doubles as the write address: it names the word being written this cycle.
    assign mem_we    = word_valid || (state == S_FILL);
    assign mem_addr  = idx[ADDR_W-1:0];
    assign mem_wdata = (state == S_FILL) ? '0 : word;

    imem_word_packer #(
        .DATA_W(DATA_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pack_clear),
        .byte_en    (pack_en),
        .byte_in    (in_data),
        .word_last  (word_last),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            len_lo   <= '0;
            n        <= '0;
            idx      <= '0;
            sum      <= '0;
            cpu_hold <= 1'b0;
            err      <= ERR_OK;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (word_valid || (state == S_FILL)) begin
                idx <= idx + ONE;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_LEN0;
                        cpu_hold <= 1'b1;
                        err      <= ERR_OK;
                        idx      <= '0;
                        sum      <= '0;
                    end
                end
                S_LEN0: begin
                    if (xfer) begin
                        len_lo <= in_data;
                        state  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        if (len16 > 16'(DEPTH)) begin
                            state <= S_DONE;
                            err   <= ERR_LEN;
                            done  <= 1'b1;
                        end else begin
                            n     <= len16[ADDR_W:0];
                            state <= (len16 == 16'd0) ? S_CHK : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // Leave on the final byte so the write cycle can already accept CHK.
                    if (xfer) begin
                        sum <= sum + in_data;
                        if (word_last && ((idx + ONE) == n)) begin
                            state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (xfer) begin
                        if (in_data == sum) begin
                            if (idx_next == DEPTH) begin
                                state    <= S_DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state <= S_FILL;
                            end
                        end else begin
                            state <= S_DONE;
                            err   <= ERR_CHK;
                            done  <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (idx == LAST_IDX) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
